// File: rtl/bingray_codec_pipe_pkg.sv
// Shared mode encoding and width-generic binary/Gray helpers (up to 32 bits).
// Callers zero-extend into 32 bits and pass the live width.
package bingray_pkg;

  typedef enum logic [1:0] {
    MODE_B2G     = 2'b00,
    MODE_G2B     = 2'b01,
    MODE_G2B_CHK = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int unsigned MAX_W = 32;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int unsigned w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from the MSB; bits above the live width are forced to zero.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int unsigned w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(w);
    b = '0;
    b[MAX_W-1] = gm[MAX_W-1];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  function automatic logic is_one_hot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/bingray_codec_pipe_if.sv
// Producer/consumer stream bundle for the binary/Gray codec, plus its error-counter sideband.
// slave = codec side, master = the surrounding producer/consumer.
interface bingray_codec_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             adj_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_cnt_clr;

  modport slave (
    input  in_valid, in_data, in_mode, adj_clr, out_ready, err_cnt_clr,
    output in_ready, out_valid, out_data, out_err, err_cnt
  );

  modport master (
    output in_valid, in_data, in_mode, adj_clr, out_ready, err_cnt_clr,
    input  in_ready, out_valid, out_data, out_err, err_cnt
  );
endinterface

// File: rtl/bingray_codec_pipe.sv
// Pipelined binary<->Gray converter with Gray adjacency check; 2-cycle latency, 1 beat/cycle.
// Backpressure: each stage advances when the next is empty or draining; out beat held while stalled.
module bingray_codec_pipe
  import bingray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bingray_codec_pipe_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_dat_q, s1_dat_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic             s1_adj_err_q, s1_adj_err_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_dat_q, s2_dat_d;
  logic             s2_err_q, s2_err_d;
  logic [WIDTH-1:0] prev_dat_q, prev_dat_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  mode_e            in_mode;
  logic             in_is_chk, prev_live;
  logic             s2_rdy, in_rdy, in_fire, out_fire;
  logic [WIDTH-1:0] conv_dat;
  logic             conv_err;

  always_comb begin
    in_mode   = mode_e'(bus.in_mode);
    in_is_chk = (in_mode == MODE_G2B_CHK);
    s2_rdy    = !s2_vld_q || bus.out_ready;
    in_rdy    = !s1_vld_q || s2_rdy;
    in_fire   = bus.in_valid && in_rdy;
    out_fire  = s2_vld_q && bus.out_ready;
    // adj_clr drops history before the same-cycle beat is compared
    prev_live = prev_vld_q && !bus.adj_clr;

    s1_vld_d     = s1_vld_q;
    s1_dat_d     = s1_dat_q;
    s1_mode_d    = s1_mode_q;
    s1_adj_err_d = s1_adj_err_q;
    prev_dat_d   = prev_dat_q;
    prev_vld_d   = prev_vld_q;

    if (in_rdy) s1_vld_d = bus.in_valid;
    if (in_fire) begin
      s1_dat_d     = bus.in_data;
      s1_mode_d    = in_mode;
      s1_adj_err_d = in_is_chk && prev_live &&
                     !is_one_hot(32'(bus.in_data) ^ 32'(prev_dat_q));
    end
    if (bus.adj_clr) prev_vld_d = 1'b0;
    if (in_fire && in_is_chk) begin
      prev_dat_d = bus.in_data;
      prev_vld_d = 1'b1;
    end

    conv_dat = s1_dat_q;
    conv_err = 1'b0;
    case (s1_mode_q)
      MODE_B2G:     conv_dat = WIDTH'(bin2gray(32'(s1_dat_q), WIDTH));
      MODE_G2B:     conv_dat = WIDTH'(gray2bin(32'(s1_dat_q), WIDTH));
      MODE_G2B_CHK: begin
        conv_dat = WIDTH'(gray2bin(32'(s1_dat_q), WIDTH));
        conv_err = s1_adj_err_q;
      end
      default:      conv_err = 1'b1;
    endcase

    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_err_d = s2_err_q;
    if (s2_rdy) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d = conv_dat;
        s2_err_d = conv_err;
      end
    end

    err_cnt_d = err_cnt_q;
    if (bus.err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (out_fire && s2_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_dat_q     <= '0;
      s1_mode_q    <= MODE_B2G;
      s1_adj_err_q <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_dat_q     <= '0;
      s2_err_q     <= 1'b0;
      prev_dat_q   <= '0;
      prev_vld_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_dat_q     <= s1_dat_d;
      s1_mode_q    <= s1_mode_d;
      s1_adj_err_q <= s1_adj_err_d;
      s2_vld_q     <= s2_vld_d;
      s2_dat_q     <= s2_dat_d;
      s2_err_q     <= s2_err_d;
      prev_dat_q   <= prev_dat_d;
      prev_vld_q   <= prev_vld_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_dat_q;
  assign bus.out_err   = s2_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
